serial_adder: RTL and testbench

- Bit-serial multi-bit adder built around the team's single-bit full-adder cell.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Feeds one bit pair per clock into the cell, LSB first, and collects sum bits and the rippled carry.
- Presents the WIDTH-bit result and carry-out over a second valid/ready handshake. It sits between an operand source and a result consumer, trading latency for area.

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/serial_adder_fa.sv | 21 ++
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared state encoding and sizing helper for the bit-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One spare bit so the counter can represent WIDTH itself even when WIDTH is a power of two.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_fa.sv
// ============================================================================
// Module  : serial_adder_fa
// Brief   : Single-bit full-adder cell.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial WIDTH-bit adder; one bit pair per clock, LSB first,
//           with valid/ready handshakes on operands and result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int                 c_cnt_w   = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
  localparam logic [1:0]         c_st_idle = ST_IDLE;
  localparam logic [1:0]         c_st_run  = ST_RUN;
  localparam logic [1:0]         c_st_done = ST_DONE;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_bit_cnt;

  logic               w_s;
  logic               w_c;
  logic               w_start_fire;
  logic [WIDTH-1:0]   w_sum_next;

  serial_adder_fa u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_s),
    .cout (w_c)
  );

  // New sum bits enter at the MSB so bit i lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_next = w_s;
    end else begin : g_sum_wn
      assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  assign start_ready  = (r_state == c_st_idle);
  assign done_valid   = (r_state == c_st_done);
  assign w_start_fire = start_valid && start_ready;
  assign sum_out      = r_sum_sh;
  assign cout         = r_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum_sh  <= '0;
      r_carry   <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_start_fire) begin
            r_a_sh    <= a_in;
            r_b_sh    <= b_in;
            r_carry   <= cin;
            r_sum_sh  <= '0;
            r_bit_cnt <= '0;
            r_state   <= c_st_run;
          end
        end
        c_st_run: begin
          r_sum_sh  <= w_sum_next;
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          r_carry   <= w_c;
          r_bit_cnt <= r_bit_cnt + c_one;
          if (r_bit_cnt == c_last) begin
            r_state <= c_st_done;
          end
        end
        c_st_done: begin
          if (done_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Self-checking bench for serial_adder at WIDTH = 8, 1 and 32.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sv [3];
  logic        dr [3];
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic        ci [3];
  wire         sr [3];
  wire         dv [3];
  wire         co [3];
  wire  [31:0] so [3];
  wire  [7:0]  so8;
  wire  [0:0]  so1;

  assign so[0] = {24'd0, so8};
  assign so[1] = {31'd0, so1};

  int lane_w [3] = '{8, 1, 32};
  int tests = 0;
  int fails = 0;
  logic [63:0] sb_q [$];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]),
    .a_in(av[0][7:0]), .b_in(bv[0][7:0]), .cin(ci[0]), .sum_out(so8),
    .cout(co[0]), .done_valid(dv[0]), .done_ready(dr[0])
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]),
    .a_in(av[1][0:0]), .b_in(bv[1][0:0]), .cin(ci[1]), .sum_out(so1),
    .cout(co[1]), .done_valid(dv[1]), .done_ready(dr[1])
  );

  serial_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[2]), .start_ready(sr[2]),
    .a_in(av[2]), .b_in(bv[2]), .cin(ci[2]), .sum_out(so[2]),
    .cout(co[2]), .done_valid(dv[2]), .done_ready(dr[2])
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {cout, sum} = a + b + cin truncated to the lane width.
  function automatic logic [63:0] model(input int k, input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    int          w;
    logic [31:0] msk;
    logic [32:0] ex;
    w   = lane_w[k];
    msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ex  = {1'b0, a & msk} + {1'b0, b & msk} + {32'd0, c};
    return {31'd0, ex[w], ex[31:0] & msk};
  endfunction

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [63:0] exp, input bit bp, input bit hold, input bit chk_lat,
                        input string tag);
    int   cyc;
    bit   sr_seen;
    logic [63:0] want;
    @(negedge clk);
    av[k] = a; bv[k] = b; ci[k] = c; sv[k] = 1'b1; dr[k] = 1'b1;
    cyc = 0;
    while (!sr[k] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!sr[k]) begin
      check({tag, " accept_timeout"}, 64'd0, 64'd1);
      sv[k] = 1'b0;
      return;
    end
    sb_q.push_back(exp);
    @(negedge clk);
    if (!hold) sv[k] = 1'b0;
    cyc     = 1;
    sr_seen = 1'b0;
    while (!dv[k] && cyc < 200) begin
      if (sr[k]) sr_seen = 1'b1;
      if (hold) begin
        av[k] = $urandom; bv[k] = $urandom; ci[k] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    if (hold) begin
      check({tag, " start_ready_in_run"}, {63'd0, sr_seen}, 64'd0);
      sv[k] = 1'b0;
    end
    if (!dv[k]) begin
      check({tag, " done_timeout"}, 64'd0, 64'd1);
      void'(sb_q.pop_front());
      return;
    end
    if (chk_lat) check({tag, " latency"}, 64'(cyc), 64'(lane_w[k] + 1));
    cyc = 0;
    forever begin
      dr[k] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dr[k] || cyc > 50) begin
        dr[k] = 1'b1;
        want  = sb_q.pop_front();
        check({tag, " result"}, {31'd0, co[k], so[k]}, want);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b0; dr[k] = 1'b1; av[k] = '0; bv[k] = '0; ci[k] = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    check("reset_state", {dv[0], sr[0], co[0], so[0]}, {1'b0, 1'b1, 1'b0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(0, {24'd0, vecs[i].a}, {24'd0, vecs[i].b}, vecs[i].c,
             {31'd0, vecs[i].co, 24'd0, vecs[i].s}, 1'b0, 1'b0, 1'b1, $sformatf("vec%0d", i));
    end

    // Operands change under start_valid while RUN; only the captured pair counts.
    run_op(0, 32'h33, 32'h44, 1'b1, 64'h78, 1'b0, 1'b1, 1'b0, "hold_inputs");

    // Backpressure: result must stay frozen, and handoff must not also accept new operands.
    @(negedge clk);
    av[0] = 32'h12; bv[0] = 32'h34; ci[0] = 1'b1; sv[0] = 1'b1; dr[0] = 1'b0;
    @(negedge clk);
    sv[0] = 1'b0;
    for (int i = 0; i < 20 && !dv[0]; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("backpressure_hold%0d", i), {dv[0], co[0], so[0]}, {1'b1, 1'b0, 32'h47});
      sv[0] = 1'b1;
      @(negedge clk);
    end
    dr[0] = 1'b1;
    @(negedge clk);
    check("handoff_to_idle", {dv[0], sr[0]}, 2'b01);
    sv[0] = 1'b0;

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    av[0] = 32'hC3; bv[0] = 32'h5A; ci[0] = 1'b1; sv[0] = 1'b1;
    @(negedge clk);
    sv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_run_reset", {dv[0], sr[0], co[0], so[0]}, {1'b0, 1'b1, 1'b0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", {63'd0, dv[0]}, 64'd0);
    run_op(0, 32'h01, 32'h01, 1'b0, 64'h02, 1'b0, 1'b0, 1'b1, "after_reset");

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
        run_op(k, ra, rb, rc, model(k, ra, rb, rc), 1'b1, 1'b0, (i < 3),
               $sformatf("rand_w%0d_%0d", lane_w[k], i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
